// File: rtl/counter_pkg.sv
// Shared definitions for the MOD-N up/down counter and its sequence monitor.
// Contents:
//   COUNT_W      default count bus width
//   MOD16/MOD11  counter moduli shared with the counter instances
//   mon_state_t  monitor FSM state encoding
package counter_pkg;

  localparam int unsigned COUNT_W = 4;
  localparam int unsigned MOD16   = 16;
  localparam int unsigned MOD11   = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    UP      = 2'd2,
    DOWN    = 2'd3
  } mon_state_t;

endpackage

// File: rtl/counter_step_compare.sv
// Combinational step classifier: compares the current sample against the
// modular successor/predecessor of the previous sample.
// Ports:
//   prev          previous accepted sample
//   cur           current sample
//   is_up         cur is the modular successor of prev
//   is_dn         cur is the modular predecessor of prev
//   is_wrap_up    up step from MOD_VALUE-1 to 0
//   is_wrap_dn    down step from 0 to MOD_VALUE-1
//   out_of_range  cur >= MOD_VALUE
module counter_step_compare #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MOD_VALUE = 16
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  output logic             is_up,
  output logic             is_dn,
  output logic             is_wrap_up,
  output logic             is_wrap_dn,
  output logic             out_of_range
);

  // One extra bit so MOD_VALUE == 2**WIDTH is representable.
  localparam logic [WIDTH:0] MOD_X  = (WIDTH+1)'(MOD_VALUE);
  localparam logic [WIDTH:0] LAST_X = (WIDTH+1)'(MOD_VALUE - 1);

  logic [WIDTH:0] prev_x;
  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] nxt_up;
  logic [WIDTH:0] nxt_dn;

  always_comb begin
    prev_x       = {1'b0, prev};
    cur_x        = {1'b0, cur};
    nxt_up       = (prev_x == LAST_X) ? '0 : prev_x + 1'b1;
    nxt_dn       = (prev_x == '0) ? LAST_X : prev_x - 1'b1;
    is_up        = (cur_x == nxt_up);
    is_dn        = (cur_x == nxt_dn);
    is_wrap_up   = is_up && (prev_x == LAST_X);
    is_wrap_dn   = is_dn && (prev_x == '0);
    out_of_range = (cur_x >= MOD_X);
  end

endmodule

// File: rtl/counter_sequence_monitor.sv
// Receive-side checker for a MOD-N up/down counter stream. Locks onto the
// counting direction and flags wraps, reversals and sequence errors.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   sample_valid      count_in is sampled on this edge
//   count_in          observed counter value
//   locked            direction established (UP or DOWN)
//   dir_down          locked on down counting
//   wrap_pulse        one-cycle pulse on a legal wrap
//   dir_change_pulse  one-cycle pulse on a legal reversal
//   error_pulse       one-cycle pulse on an illegal sample
//   error_count       saturating error count
module counter_sequence_monitor
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = COUNT_W,
  parameter int unsigned MOD_VALUE = MOD16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     count_in,
  output logic                 locked,
  output logic                 dir_down,
  output logic                 wrap_pulse,
  output logic                 dir_change_pulse,
  output logic                 error_pulse,
  output logic [ERR_CNT_W-1:0] error_count
);

  mon_state_t       state, state_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic             wrap_nxt, chg_nxt, err_nxt;
  logic             is_up, is_dn, is_wrap_up, is_wrap_dn, out_of_range;

  counter_step_compare #(
    .WIDTH     (WIDTH),
    .MOD_VALUE (MOD_VALUE)
  ) u_cmp (
    .prev         (prev),
    .cur          (count_in),
    .is_up        (is_up),
    .is_dn        (is_dn),
    .is_wrap_up   (is_wrap_up),
    .is_wrap_dn   (is_wrap_dn),
    .out_of_range (out_of_range)
  );

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    wrap_nxt  = 1'b0;
    chg_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (sample_valid) begin
      if (out_of_range) begin
        // prev is kept; a locked monitor drops back to reacquisition.
        err_nxt = 1'b1;
        if (state == UP || state == DOWN) state_nxt = ACQUIRE;
      end else begin
        prev_nxt = count_in;
        unique case (state)
          IDLE: state_nxt = ACQUIRE;
          ACQUIRE: begin
            if (is_up) begin
              state_nxt = UP;
              wrap_nxt  = is_wrap_up;
            end else if (is_dn) begin
              state_nxt = DOWN;
              wrap_nxt  = is_wrap_dn;
            end else begin
              err_nxt   = 1'b1;
            end
          end
          UP, DOWN: begin
            if (is_up) begin
              state_nxt = UP;
              wrap_nxt  = is_wrap_up;
              chg_nxt   = (state == DOWN);
            end else if (is_dn) begin
              state_nxt = DOWN;
              wrap_nxt  = is_wrap_dn;
              chg_nxt   = (state == UP);
            end else begin
              state_nxt = ACQUIRE;
              err_nxt   = 1'b1;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      prev             <= '0;
      locked           <= 1'b0;
      dir_down         <= 1'b0;
      wrap_pulse       <= 1'b0;
      dir_change_pulse <= 1'b0;
      error_pulse      <= 1'b0;
      error_count      <= '0;
    end else begin
      state            <= state_nxt;
      prev             <= prev_nxt;
      locked           <= (state_nxt == UP) || (state_nxt == DOWN);
      dir_down         <= (state_nxt == DOWN);
      wrap_pulse       <= wrap_nxt;
      dir_change_pulse <= chg_nxt;
      error_pulse      <= err_nxt;
      if (err_nxt && (error_count != '1)) error_count <= error_count + 1'b1;
    end
  end

endmodule

// File: doc/counter_sequence_monitor.md
Name: counter_sequence_monitor

Overview:
- Receive-side checker for the 4-bit modulo up/down counter stream.
- Samples a count bus every qualified clock, locks onto the counting direction, and flags wrap-arounds, direction reversals and sequence errors.
- Sits beside any MOD-N up/down counter instance in the design; the bench uses it as a self-checking scoreboard.

Parameters:
- WIDTH, 4, width of count bus.
- MOD_VALUE, 16, counter modulus. Legal sequence is 0..MOD_VALUE-1. Legal range is 3..2^WIDTH; use 11 for MOD-11 counters.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- rst_n  input  1  synchronous active-low reset.
- sample_valid  input  1  count_in is sampled on this edge.
- count_in  input  WIDTH  observed counter value.
- locked  output  1  direction established (state UP or DOWN).
- dir_down  output  1  1 = locked on down counting; 0 otherwise.
- wrap_pulse  output  1  one-cycle pulse on a legal wrap.
- dir_change_pulse  output  1  one-cycle pulse on a legal reversal.
- error_pulse  output  1  one-cycle pulse on an illegal sample.
- error_count  output  ERR_CNT_W  saturating count of errors.

Behaviour:
- Reset is synchronous: on the rising edge with rst_n=0, state goes to IDLE, the internal prev register goes to 0, and all outputs go to 0. Reset overrides sample_valid on the same edge.
- All outputs are registered. Pulses are high for exactly the one cycle following the accepting edge. Latency is 1 cycle from sample edge to flag.
- With sample_valid=0, state, prev and error_count hold and all pulses are 0.
- Modular arithmetic: nxt_up = (prev==MOD_VALUE-1) ? 0 : prev+1; nxt_dn = (prev==0) ? MOD_VALUE-1 : prev-1.
- out_of_range = count_in >= MOD_VALUE. An out-of-range sample is always an error in every state.
- States: IDLE, ACQUIRE, UP, DOWN. Each valid sample updates prev to count_in, except out-of-range samples, which leave prev unchanged.
- IDLE:
  - In-range sample -> ACQUIRE.
  - Out-of-range sample -> error_pulse, stay IDLE.
- ACQUIRE:
  - count_in==nxt_up -> UP.
  - count_in==nxt_dn -> DOWN, dir_down=1.
  - Any other value -> error_pulse, stay ACQUIRE, new prev.
  - Wrap seen during acquisition also raises wrap_pulse.
- UP:
  - count_in==nxt_up -> stay UP. wrap_pulse if prev==MOD_VALUE-1.
  - count_in==nxt_dn -> DOWN, dir_change_pulse. wrap_pulse if prev==0.
  - Otherwise, including a repeated value -> error_pulse, go to ACQUIRE, locked=0.
- DOWN: symmetric to UP.
- MOD_VALUE>=3 guarantees nxt_up != nxt_dn, so there is no ambiguity.
- error_count increments on each error_pulse event and saturates at 2^ERR_CNT_W-1. It clears only on reset.
- locked = state is UP or DOWN. dir_down = state is DOWN. Both are registered with the state.

Decomposition:
- Package counter_pkg holds:
  - monitor state encoding constants (IDLE=2'd0, ACQUIRE=2'd1, UP=2'd2, DOWN=2'd3);
  - default COUNT_W=4;
  - MOD constants 16 and 11, shared with the counter.
- One combinational sub-module, counter_step_compare (params WIDTH, MOD_VALUE):
  - inputs prev and cur;
  - outputs is_up, is_dn, is_wrap_up, is_wrap_dn, out_of_range.
- The top holds the FSM, prev register, pulse registers and saturating counter.

Test Plan:
- Reset behaviour: sample_valid=1 and count_in=5 with rst_n=0 for 3 clocks -> all outputs 0, error_count=0. After release, the first sample 5 -> not locked.
- Up lock and wrap (MOD 16): samples 0,1,...,15,0,1 -> locked=1 and dir_down=0 one cycle after sample 1; wrap_pulse exactly once, the cycle after sample 0 following 15; error_count=0.
- Reversal and down wrap: samples 7,8,9,8,7 -> dir_change_pulse once after the second 8, dir_down=1. Then continuing 1,0,15 gives wrap_pulse after 15.
- Skip error and reacquire: locked UP at 3, then sample 5 -> error_pulse, locked=0, error_count=1. Then samples 6,7 -> locked UP again after 6.
- MOD 11 range: MOD_VALUE=11, samples 9,10,0 -> wrap_pulse after 0. Sample 12 -> error_pulse and prev unchanged, so the next sample 1 continues UP with no further error.
- Saturation and gating: 300 alternating illegal samples (0,5,0,5,...) -> error_count=255 and held there. With sample_valid=0 for 10 clocks, no pulses and state is unchanged.
